// File: rtl/fp_pkg.sv
// Shared constants and stage payload types for the mantissa add/normalise stage.
// No ports; imported by the interface, the top and the leading-zero counter.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  // hidden bit + fraction + guard/round/sticky
  localparam int unsigned GM_W   = FRAC_W + 4;
  // Wide enough to hold a count of 0..27
  localparam int unsigned LZC_W  = 5;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Result of the add/subtract stage; sum carries one extra bit for the carry-out
  typedef struct packed {
    logic [GM_W:0]    sum;
    logic [EXP_W-1:0] e;
    logic             sign;
    logic             zero;
  } add_res_t;

  // Add result plus its leading-zero count, as consumed by the normaliser
  typedef struct packed {
    add_res_t         add;
    logic [LZC_W-1:0] lz;
  } lzc_res_t;

endpackage

// File: rtl/fp_mant_add_norm_if.sv
// Handshake and data bundle for fp_mant_add_norm.
// Input side : in_valid/in_ready, e_in, sign_1, sign_2, m_1, m_2.
// Output side: out_valid/out_ready, sign_out, e_out, m_out, is_zero, overflow.
// master = the environment (aligner upstream, rounder downstream); slave = the block.
interface fp_mant_add_norm_if;
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] e_in;
  logic             sign_1;
  logic             sign_2;
  logic [GM_W-1:0]  m_1;
  logic [GM_W-1:0]  m_2;

  logic             out_valid;
  logic             out_ready;
  logic             sign_out;
  logic [EXP_W-1:0] e_out;
  logic [GM_W-1:0]  m_out;
  logic             is_zero;
  logic             overflow;

  modport master (
    output in_valid, e_in, sign_1, sign_2, m_1, m_2, out_ready,
    input  in_ready, out_valid, sign_out, e_out, m_out, is_zero, overflow
  );

  modport slave (
    input  in_valid, e_in, sign_1, sign_2, m_1, m_2, out_ready,
    output in_ready, out_valid, sign_out, e_out, m_out, is_zero, overflow
  );

endinterface

// File: rtl/lzc27.sv
// Combinational leading-zero counter over a 27-bit word.
// Ports: din (27-bit word), count (0..27; 27 means din is all zero).
module lzc27
  import fp_pkg::*;
(
  input  logic [GM_W-1:0]  din,
  output logic [LZC_W-1:0] count
);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    count = LZC_W'(GM_W);
    for (int i = 0; i < GM_W; i++) begin
      if (din[i]) count = LZC_W'(GM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_mant_add_norm.sv
// Floating-point mantissa add/subtract and normalise stage, between aligner and rounder.
// Ports: clk, rst (synchronous, active-high), bus (fp_mant_add_norm_if.slave).
// S1 performs the effective add/subtract on magnitudes; S2 normalises with an LZC and shift
// and drives the outputs. Latency 2 with no stall.
// Optional macro FP_MANT_ADD_NORM_LZC_REG_EN: registers the LZC result ahead of the shifter,
// giving latency 3 with the same handshake behaviour.
module fp_mant_add_norm
  import fp_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fp_mant_add_norm_if.slave bus
);

  // ---------------------------------------------------------------- S1: add / subtract
  add_res_t s1_d, s1_q;
  logic     s1_valid_q;
  logic     s1_adv;
  logic     s1_take;  // stage after S1 accepts its item this cycle

  always_comb begin
    s1_d      = '0;
    s1_d.e    = bus.e_in;
    s1_d.sign = bus.sign_1;
    if (!(bus.sign_1 ^ bus.sign_2)) begin
      s1_d.sum = {1'b0, bus.m_1} + {1'b0, bus.m_2};
    end else if (bus.m_1 >= bus.m_2) begin
      s1_d.sum = {1'b0, bus.m_1 - bus.m_2};
    end else begin
      // Equal exponents give no ordering guarantee; operand 2 dominates here
      s1_d.sum  = {1'b0, bus.m_2 - bus.m_1};
      s1_d.sign = bus.sign_2;
    end
    s1_d.zero = (s1_d.sum == '0);
    // Exact cancellation yields +0 under round-to-nearest
    if (s1_d.zero) s1_d.sign = 1'b0;
  end

  assign s1_adv      = !s1_valid_q || s1_take;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------- leading-zero count
  logic [LZC_W-1:0] s1_lz;

  lzc27 u_lzc (
    .din   (s1_q.sum[GM_W-1:0]),
    .count (s1_lz)
  );

  lzc_res_t norm_in;
  logic     norm_valid;
  logic     out_valid_q;
  logic     s2_adv;

  assign s2_adv = !out_valid_q || bus.out_ready;

`ifdef FP_MANT_ADD_NORM_LZC_REG_EN
  lzc_res_t lz_q;
  logic     lz_valid_q;
  logic     lz_adv;

  assign lz_adv  = !lz_valid_q || s2_adv;
  assign s1_take = lz_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_valid_q <= 1'b0;
      lz_q       <= '0;
    end else if (lz_adv) begin
      lz_valid_q <= s1_valid_q;
      if (s1_valid_q) lz_q <= '{add: s1_q, lz: s1_lz};
    end
  end

  assign norm_in    = lz_q;
  assign norm_valid = lz_valid_q;
`else
  assign s1_take    = s2_adv;
  assign norm_in    = '{add: s1_q, lz: s1_lz};
  assign norm_valid = s1_valid_q;
`endif

  // ---------------------------------------------------------------- S2: normalise
  logic [EXP_W:0]   e_inc;
  logic [EXP_W-1:0] e_m1;
  logic [LZC_W-1:0] shamt;
  logic [GM_W-1:0]  m_sh;
  logic             n_sign;
  logic [EXP_W-1:0] n_e;
  logic [GM_W-1:0]  n_m;
  logic             n_zero;
  logic             n_ovf;

  always_comb begin
    e_inc  = {1'b0, norm_in.add.e} + 1'b1;
    e_m1   = norm_in.add.e - 1'b1;
    shamt  = '0;
    m_sh   = '0;
    n_sign = norm_in.add.sign;
    n_e    = '0;
    n_m    = '0;
    n_zero = 1'b0;
    n_ovf  = 1'b0;
    if (norm_in.add.zero) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
    end else if (norm_in.add.sum[GM_W]) begin
      // Carry-out: shift right one, folding the dropped bit into sticky
      if (e_inc >= {1'b0, EXP_MAX}) begin
        n_ovf = 1'b1;
        n_e   = EXP_MAX;
      end else begin
        n_e = e_inc[EXP_W-1:0];
        n_m = {norm_in.add.sum[GM_W:2], norm_in.add.sum[1] | norm_in.add.sum[0]};
      end
    end else begin
      // Left shift limited so the exponent never drops below 1
      if (norm_in.add.e != '0) begin
        shamt = (EXP_W'(norm_in.lz) < e_m1) ? norm_in.lz : e_m1[LZC_W-1:0];
      end
      m_sh = norm_in.add.sum[GM_W-1:0] << shamt;
      n_m  = m_sh;
      n_e  = m_sh[GM_W-1] ? (norm_in.add.e - EXP_W'(shamt)) : '0;
    end
  end

  logic             sign_q;
  logic [EXP_W-1:0] e_q;
  logic [GM_W-1:0]  m_q;
  logic             zero_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= norm_valid;
      if (norm_valid) begin
        sign_q <= n_sign;
        e_q    <= n_e;
        m_q    <= n_m;
        zero_q <= n_zero;
        ovf_q  <= n_ovf;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sign_out  = sign_q;
  assign bus.e_out     = e_q;
  assign bus.m_out     = m_q;
  assign bus.is_zero   = zero_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_fp_mant_add_norm.sv
// Self-checking bench for fp_mant_add_norm: directed arithmetic cases, back-pressure,
// mid-flight reset and randomized traffic scored against an arithmetic reference model.
module tb_fp_mant_add_norm;
  import fp_pkg::*;

`ifdef FP_MANT_ADD_NORM_LZC_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic        sign;
    logic [7:0]  e;
    logic [26:0] m;
    logic        zero;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs = 0;
  res_t exp_q[$];
  res_t held;
  bit   hold_prev = 1'b0;
  bit   acc = 1'b0;
  int   n_pop = 0;

  fp_mant_add_norm_if bus ();

  fp_mant_add_norm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // Reference: exact magnitude arithmetic, then normalise by repeated doubling
  function automatic res_t model(logic [7:0] e_in, logic s1, logic s2,
                                 logic [26:0] m1, logic [26:0] m2);
    res_t   r;
    longint a, b, sum;
    int     e;
    logic   sg;
    r = '0;
    a = longint'(m1);
    b = longint'(m2);
    if (s1 == s2) begin
      sum = a + b; sg = s1;
    end else if (a >= b) begin
      sum = a - b; sg = s1;
    end else begin
      sum = b - a; sg = s2;
    end
    if (sum == 0) begin
      r.zero = 1'b1;
      return r;
    end
    r.sign = sg;
    e = int'(e_in);
    if (sum >= (longint'(1) << 27)) begin
      e = e + 1;
      if (e >= 255) begin
        r.ovf = 1'b1;
        r.e   = 8'hFF;
      end else begin
        r.e = 8'(e);
        r.m = 27'((sum >> 1) | (sum & 1));
      end
    end else begin
      if (e != 0) begin
        while (sum < (longint'(1) << 26) && e > 1) begin
          sum = sum * 2;
          e   = e - 1;
        end
      end
      r.m = 27'(sum);
      r.e = (sum >= (longint'(1) << 26)) ? 8'(e) : 8'd0;
    end
    return r;
  endfunction

  function automatic res_t out_word();
    res_t r;
    r.sign = bus.sign_out;
    r.e    = bus.e_out;
    r.m    = bus.m_out;
    r.zero = bus.is_zero;
    r.ovf  = bus.overflow;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] e, input logic s1, input logic s2,
                       input logic [26:0] m1, input logic [26:0] m2);
    bus.in_valid = v;
    bus.e_in     = e;
    bus.sign_1   = s1;
    bus.sign_2   = s2;
    bus.m_1      = m1;
    bus.m_2      = m2;
  endtask

  task automatic drive_rand(input logic v);
    logic [7:0]  e;
    logic [26:0] m1, m2;
    case ($urandom_range(0, 3))
      0:       e = 8'($urandom_range(0, 2));
      1:       e = 8'($urandom_range(252, 254));
      default: e = 8'($urandom_range(0, 254));
    endcase
    case ($urandom_range(0, 3))
      0:       m1 = 27'($urandom);
      1:       m1 = {1'b1, 26'($urandom)};
      default: m1 = 27'($urandom) >> $urandom_range(0, 26);
    endcase
    case ($urandom_range(0, 3))
      0:       m2 = m1 ^ 27'($urandom_range(0, 15));
      1:       m2 = m1;
      2:       m2 = {1'b1, 26'($urandom)};
      default: m2 = 27'($urandom) >> $urandom_range(0, 26);
    endcase
    drive(v, e, 1'($urandom), 1'($urandom), m1, m2);
  endtask

  // Called at a falling edge with inputs already set; scores this cycle, ends at next fall
  task automatic step();
    res_t exp_r;
    #1;
    acc = 1'b0;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.e_in, bus.sign_1, bus.sign_2, bus.m_1, bus.m_2));
        acc = 1'b1;
      end
      if (hold_prev) check_eq("hold_stable", {bus.out_valid, out_word()}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        check_eq("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_r = exp_q.pop_front();
          n_pop++;
          check_eq("result", 64'(out_word()), 64'(exp_r));
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      held      = out_word();
    end
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [7:0] e, input logic s1, input logic s2,
                          input logic [26:0] m1, input logic [26:0] m2, input logic esg,
                          input logic [7:0] ee, input logic [26:0] em, input logic ez,
                          input logic eo);
    drive(1'b1, e, s1, s2, m1, m2);
    step();
    check_eq({tag, "_acc"}, 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    for (int j = 1; j < LAT; j++) begin
      check_eq({tag, "_early"}, 64'(bus.out_valid), 64'd0);
      step();
    end
    check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check_eq({tag, "_sign"}, 64'(bus.sign_out), 64'(esg));
    check_eq({tag, "_e"}, 64'(bus.e_out), 64'(ee));
    check_eq({tag, "_m"}, 64'(bus.m_out), 64'(em));
    check_eq({tag, "_zero"}, 64'(bus.is_zero), 64'(ez));
    check_eq({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    step();
  endtask

  initial begin
    int idx;
    int pops0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 27'd0, 27'd0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_word", 64'(out_word()), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

    directed("add_3p2", 8'd128, 1'b0, 1'b0, 27'h6000000, 27'h4000000,
             1'b0, 8'd129, 27'h5000000, 1'b0, 1'b0);
    directed("cancel_near", 8'd127, 1'b0, 1'b1, 27'h4000000, 27'h3FFFFFC,
             1'b0, 8'd103, 27'h4000000, 1'b0, 1'b0);
    directed("cancel_exact", 8'd128, 1'b0, 1'b1, 27'h6000000, 27'h6000000,
             1'b0, 8'd0, 27'h0, 1'b1, 1'b0);
    directed("swap", 8'd128, 1'b0, 1'b1, 27'h4000000, 27'h6000000,
             1'b1, 8'd127, 27'h4000000, 1'b0, 1'b0);
    directed("overflow", 8'd254, 1'b0, 1'b0, 27'h7FFFFF8, 27'h7FFFFF8,
             1'b0, 8'd255, 27'h0, 1'b0, 1'b1);

    // Back-pressure: three items against a stalled output
    bus.out_ready = 1'b0;
    idx = 0;
    pops0 = n_pop;
    drive_rand(1'b1);
    for (int c = 0; c < 8; c++) begin
      step();
      if (acc) begin
        idx++;
        if (idx < 3) drive_rand(1'b1);
        else bus.in_valid = 1'b0;
      end
    end
    check_eq("bp_accepted", 64'(idx), 64'(LAT));
    check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 3 && exp_q.size() == 0); c++) begin
      step();
      if (acc) begin
        idx++;
        if (idx < 3) drive_rand(1'b1);
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("bp_pops", 64'(n_pop - pops0), 64'd3);

    // Reset with two items in flight
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 2; c++) begin
      drive_rand(1'b1);
      step();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    check_eq("rst_inflight_acc", 64'(idx), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    check_eq("rst_flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    pops0 = n_pop;
    for (int c = 0; c < 6; c++) begin
      check_eq("rst_no_emit", 64'(bus.out_valid), 64'd0);
      step();
    end

    // Randomized traffic with random stalls on both sides
    for (int c = 0; c < 1500; c++) begin
      drive_rand(1'($urandom_range(0, 3) != 0));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/fp_mant_add_norm.md
Name: fp_mant_add_norm

Overview:
- Floating-point adder stage that sits directly downstream of the aligner and consumes its outputs: common exponent, operand signs, and two 27-bit aligned guarded significands.
- Guarded significand layout: hidden bit, 23 fraction bits, then guard, round and sticky bits.
- Performs the effective add or subtract on magnitudes, then normalises the result with a leading-zero count and shift.
- Pipelined with valid/ready handshakes; hands a normalised 27-bit significand and exponent to the rounder/packer.

Parameters:
- EXP_W, 8, exponent width.
- GM_W, 27, guarded significand width (1 hidden + 23 fraction + 3 GRS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block can accept input this cycle.
- e_in  in  EXP_W  common (larger) exponent from the aligner.
- sign_1  in  1  sign of operand 1.
- sign_2  in  1  effective sign of operand 2 (already op-adjusted).
- m_1  in  GM_W  aligned guarded significand 1.
- m_2  in  GM_W  aligned guarded significand 2.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sign_out  out  1  result sign.
- e_out  out  EXP_W  result exponent.
- m_out  out  GM_W  normalised guarded significand; bit 26 set unless zero or subnormal.
- is_zero  out  1  exact-zero result.
- overflow  out  1  exponent reached 255.

Behaviour:
- Reset: all valid flags, out_valid, sign_out, e_out, m_out, is_zero and overflow clear to 0. in_ready = 1 in the cycle after reset. Reset mid-operation discards all in-flight items; nothing is emitted for them.
- Handshake: a transfer occurs when valid && ready on the same edge.
- Pipeline: 2 register stages, S1 then S2 (S2 drives the outputs). Latency from input transfer to out_valid is 2 cycles with no stall.
- A stage advances when it is empty or the stage after it advances. in_ready = !s1_valid || s1 advances. in_ready is combinational from out_ready and may change within a cycle.
- Outputs hold stable while out_valid && !out_ready.
- S1, arithmetic:
  - eff_sub = sign_1 ^ sign_2.
  - Add: sum = {0,m_1} + {0,m_2}, 28 bits; sign = sign_1.
  - Subtract: if m_1 >= m_2 then sum = m_1 - m_2, sign = sign_1; otherwise sum = m_2 - m_1, sign = sign_2. The aligner does not guarantee m_1 >= m_2 when the exponents are equal.
  - A sum of exactly 0 sets zero; sign is forced to 0 (round-to-nearest rule).
  - e_in is registered unchanged.
- S2, normalise:
  - sum[27]=1: m = sum[27:1], with bit 0 = sum[1] | sum[0] (sticky preserved); e = e+1. If the new e == 255, overflow=1 and m_out=0.
  - Otherwise: lz = leading zeros of sum[26:0]. shift = min(lz, e-1) when e >= 1; shift = 0 when e = 0. m = sum[26:0] << shift; e = e - shift.
  - If bit 26 of the shifted m is still 0, e_out = 0 (subnormal).
  - zero: m_out = 0, e_out = 0, is_zero = 1.
- No rounding in this block; GRS bits are passed through for the rounder.

Optional Feature:
- Macro: FP_MANT_ADD_NORM_LZC_REG_EN.
- Defined: adds a register stage between the LZC and the shifter, holding sum, lz, e, sign and flags. Latency is 3; handshake rules are unchanged.
- Undefined: LZC and shifter share S2; latency 2.

Decomposition:
- Shared package fp_pkg holds: EXP_W, FRAC_W=23, GM_W=27, EXP_MAX=8'hFF, and the LZC width constant (5 bits).
- Natural sub-module: lzc27, a combinational 27-bit leading-zero counter returning 0..27.

Test Plan:
- 3+2: e_in=128, m_1=27'h6000000, m_2=27'h4000000, signs 0 -> after 2 cycles: m_out=27'h5000000, e_out=129, sign_out=0 (=5.0).
- 1 + -(1-2^-24): e_in=127, m_1=27'h4000000, m_2=27'h3FFFFFC, sign_2=1 -> m_out=27'h4000000, e_out=103, sign_out=0.
- 3 + -3: e_in=128, m_1=m_2=27'h6000000, sign_2=1 -> is_zero=1, sign_out=0, e_out=0, m_out=0.
- Swap case: m_1=27'h4000000, m_2=27'h6000000, sign_1=0, sign_2=1, e_in=128 -> sign_out=1, m_out=27'h4000000, e_out=127.
- Overflow: e_in=254, m_1=m_2=27'h7FFFFF8, add -> overflow=1, e_out=255, m_out=0.
- Back-pressure and reset:
  - Hold out_ready=0 and push 3 items -> in_ready=0 after 2 are accepted; outputs stay stable; releasing out_ready yields all items in order.
  - Assert rst with 2 items in flight -> out_valid=0 next cycle; nothing emitted for those items.
